// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the 512-byte memory-mapped GPIO/RAM bus.
// Turns CPU byte/halfword read/write requests into single-byte bus cycles,
// waits out the responder read latency, assembles little-endian halfwords
// and suppresses writes to the read-only input bytes RO_LO..RO_HI.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req, we, size       request strobe (sampled while ready), write, halfword
//   addr, wdata         byte address, write data ([7:0] -> addr, [15:8] -> addr+1)
//   ready               high while idle and able to accept a request
//   done, err           one-cycle completion pulse, suppressed-write flag
//   rdata               read result, held until the next read completes
//   mem_rw_select       responder write enable
//   mem_address         responder byte address
//   mem_wdata           responder write data
//   mem_rdata           responder read data
module mem_bus_master #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RO_LO        = 503,
    parameter int unsigned RO_HI        = 505
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [8:0]  addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_rw_select,
    output logic [8:0]  mem_address,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] LAST_WAIT = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    logic            we_q;
    logic            size_q;
    logic [AW-1:0]   addr_q;
    logic [15:0]     wdata_q;
    logic            k;
    logic            err_acc;
    logic [CW-1:0]   wait_cnt;
    logic [DW-1:0]   lo_byte;
    logic [AW-1:0]   next_addr_c;

    // Address of the second byte; 9-bit arithmetic wraps 511 -> 0.
    assign next_addr_c = addr_q + AW'(1);

    function automatic logic is_ro(input logic [AW-1:0] a);
        return (a >= AW'(RO_LO)) && (a <= AW'(RO_HI));
    endfunction

    // Bus outputs are registered on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ready         <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= 16'h0000;
            mem_rw_select <= 1'b0;
            mem_address   <= '0;
            mem_wdata     <= '0;
            we_q          <= 1'b0;
            size_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            k             <= 1'b0;
            err_acc       <= 1'b0;
            wait_cnt      <= '0;
            lo_byte       <= '0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            mem_rw_select <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q        <= we;
                        size_q      <= size;
                        addr_q      <= addr;
                        wdata_q     <= wdata;
                        k           <= 1'b0;
                        err_acc     <= 1'b0;
                        mem_address <= addr;
                        if (we) begin
                            mem_wdata     <= wdata[7:0];
                            mem_rw_select <= ~is_ro(addr);
                        end
                        ready <= 1'b0;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (we_q) begin
                        // A suppressed byte is the one currently on the bus.
                        if (size_q && !k) begin
                            k             <= 1'b1;
                            err_acc       <= err_acc | is_ro(mem_address);
                            mem_address   <= next_addr_c;
                            mem_wdata     <= wdata_q[15:8];
                            mem_rw_select <= ~is_ro(next_addr_c);
                        end else begin
                            err   <= err_acc | is_ro(mem_address);
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        if (size_q && !k) begin
                            lo_byte     <= mem_rdata;
                            k           <= 1'b1;
                            mem_address <= next_addr_c;
                            state       <= ADDR;
                        end else begin
                            rdata <= size_q ? {mem_rdata, lo_byte} : {8'h00, mem_rdata};
                            err   <= err_acc;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Testbench for mem_bus_master: two instances (read latency 1 and 3), each
// with a bench-side responder memory, a transaction-level expected-trace model
// and a per-cycle compare process, plus literal checks of key results.
module tb_mem_bus_master;

    localparam int unsigned LAT0  = 1;
    localparam int unsigned LAT1  = 3;
    localparam int unsigned RO_LO = 503;
    localparam int unsigned RO_HI = 505;

    typedef struct {
        logic        rw;
        logic [8:0]  addr;
        logic [7:0]  wd;
        logic        chk_wd;
        logic        done;
        logic        err;
        logic [15:0] rd;
        logic        ready;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [2];
    logic        req   [2];
    logic        we    [2];
    logic        size  [2];
    logic [8:0]  addr  [2];
    logic [15:0] wdata [2];
    logic        ready [2];
    logic        done  [2];
    logic        err   [2];
    logic [15:0] rdata [2];
    logic        mrw   [2];
    logic [8:0]  maddr [2];
    logic [7:0]  mwd   [2];
    logic [7:0]  mrd   [2];

    mem_bus_master #(.READ_LATENCY(LAT0), .RO_LO(RO_LO), .RO_HI(RO_HI)) dut0 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .size(size[0]),
        .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .done(done[0]),
        .rdata(rdata[0]), .err(err[0]), .mem_rw_select(mrw[0]),
        .mem_address(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
    );

    mem_bus_master #(.READ_LATENCY(LAT1), .RO_LO(RO_LO), .RO_HI(RO_HI)) dut1 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .size(size[1]),
        .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .done(done[1]),
        .rdata(rdata[1]), .err(err[1]), .mem_rw_select(mrw[1]),
        .mem_address(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
    );

    // Responder: byte memory with a registered read pipeline of depth LATn.
    logic       tb_init;
    logic [7:0] rmem [2][512];
    logic [8:0] pipe [2][3];

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0:       return 8'hAB;
            504:     return 8'h34;
            505:     return 8'h12;
            511:     return 8'hCD;
            default: return 8'(i) ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 512; i++) begin
                rmem[0][i] = init_byte(i);
                rmem[1][i] = init_byte(i);
            end
            pipe[0][0] <= '0; pipe[0][1] <= '0; pipe[0][2] <= '0;
            pipe[1][0] <= '0; pipe[1][1] <= '0; pipe[1][2] <= '0;
        end else begin
            if (mrw[0] === 1'b1) rmem[0][maddr[0]] = mwd[0];
            if (mrw[1] === 1'b1) rmem[1][maddr[1]] = mwd[1];
            pipe[0][0] <= maddr[0]; pipe[0][1] <= pipe[0][0]; pipe[0][2] <= pipe[0][1];
            pipe[1][0] <= maddr[1]; pipe[1][1] <= pipe[1][0]; pipe[1][2] <= pipe[1][1];
        end
    end

    assign mrd[0] = rmem[0][pipe[0][LAT0-1]];
    assign mrd[1] = rmem[1][pipe[1][LAT1-1]];

    // Model state and bookkeeping.
    logic [7:0]  ref_mem [2][512];
    logic [15:0] last_rd [2];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cyc [2];
    int          done_cnt [2];
    int          rw_cnt   [2];
    logic        last_err [2];
    bit          checking = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic logic in_ro(input logic [8:0] a);
        return (a >= 9'(RO_LO)) && (a <= 9'(RO_HI));
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Expected per-cycle bus/handshake trace of one accepted request.
    function automatic void push_trace(input int d, input logic w, input logic s,
                                       input logic [8:0] a, input logic [15:0] wd);
        exp_t        e;
        int          n;
        logic        any_ro;
        logic [8:0]  ba;
        logic [7:0]  b;
        logic [7:0]  rb0;
        logic [7:0]  rb1;
        logic [15:0] rd_new;
        n = s ? 2 : 1;
        any_ro = 1'b0;
        rb0 = 8'h00;
        rb1 = 8'h00;
        ba = a;
        for (int j = 0; j < n; j++) begin
            ba = 9'((int'(a) + j) % 512);
            b  = (j == 0) ? wd[7:0] : wd[15:8];
            if (w) begin
                e = '{rw: !in_ro(ba), addr: ba, wd: b, chk_wd: 1'b1, done: 1'b0,
                      err: 1'b0, rd: last_rd[d], ready: 1'b0};
                if (in_ro(ba)) any_ro = 1'b1;
                else           ref_mem[d][ba] = b;
                qpush(d, e);
            end else begin
                for (int c = 0; c <= lat(d); c++) begin
                    e = '{rw: 1'b0, addr: ba, wd: 8'h00, chk_wd: 1'b0, done: 1'b0,
                          err: 1'b0, rd: last_rd[d], ready: 1'b0};
                    qpush(d, e);
                end
                if (j == 0) rb0 = ref_mem[d][ba];
                else        rb1 = ref_mem[d][ba];
            end
        end
        rd_new = w ? last_rd[d] : {rb1, rb0};
        e = '{rw: 1'b0, addr: ba, wd: 8'h00, chk_wd: 1'b0, done: 1'b1,
              err: any_ro, rd: rd_new, ready: 1'b0};
        qpush(d, e);
        last_rd[d] = rd_new;
        e = '{rw: 1'b0, addr: ba, wd: 8'h00, chk_wd: 1'b0, done: 1'b0,
              err: 1'b0, rd: rd_new, ready: 1'b1};
        qpush(d, e);
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                if (qsize(d) > 0) begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("dut%0d ready", d), 32'(ready[d]), 32'(e.ready));
                    chk($sformatf("dut%0d done", d), 32'(done[d]), 32'(e.done));
                    chk($sformatf("dut%0d mem_rw_select", d), 32'(mrw[d]), 32'(e.rw));
                    chk($sformatf("dut%0d mem_address", d), 32'(maddr[d]), 32'(e.addr));
                    chk($sformatf("dut%0d rdata", d), 32'(rdata[d]), 32'(e.rd));
                    if (e.chk_wd) chk($sformatf("dut%0d mem_wdata", d), 32'(mwd[d]), 32'(e.wd));
                    if (e.done)   chk($sformatf("dut%0d err", d), 32'(err[d]), 32'(e.err));
                end else begin
                    chk($sformatf("dut%0d idle ready", d), 32'(ready[d]), 32'd1);
                    chk($sformatf("dut%0d idle done", d), 32'(done[d]), 32'd0);
                    chk($sformatf("dut%0d idle mem_rw_select", d), 32'(mrw[d]), 32'd0);
                    chk($sformatf("dut%0d idle rdata", d), 32'(rdata[d]), 32'(last_rd[d]));
                end
                if (done[d] === 1'b1) begin
                    done_cyc[d] = cyc;
                    done_cnt[d]++;
                    last_err[d] = err[d];
                end
                if (mrw[d] === 1'b1) rw_cnt[d]++;
            end
        end
    end

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0) begin
            if (n >= 100) begin
                vectors++;
                miscompares++;
                $display("FAIL dut%0d drain timeout: %0d cycles, %0d entries left", d, n, qsize(d));
                if (d == 0) q0.delete();
                else        q1.delete();
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Present one request for one cycle; c0 is the acceptance cycle.
    task automatic issue(input int d, input logic w, input logic s, input logic [8:0] a,
                         input logic [15:0] wd, output int c0);
        wait_drain(d);
        @(negedge clk);
        c0 = cyc;
        req[d] = 1'b1; we[d] = w; size[d] = s; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        push_trace(d, w, s, a, wd);
    endtask

    task automatic run(input int d, input logic w, input logic s, input logic [8:0] a,
                       input logic [15:0] wd, input int exp_lat);
        int c0;
        issue(d, w, s, a, wd, c0);
        wait_drain(d);
        chk($sformatf("dut%0d latency", d), 32'(done_cyc[d] - c0), 32'(exp_lat));
    endtask

    initial begin
        int r0;
        int dc;
        int c0;
        tb_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; last_rd[d] = 16'h0000;
            done_cyc[d] = 0; done_cnt[d] = 0; rw_cnt[d] = 0; last_err[d] = 1'b0;
            for (int i = 0; i < 512; i++) ref_mem[d][i] = init_byte(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset ready", d), 32'(ready[d]), 32'd1);
            chk($sformatf("dut%0d reset done", d), 32'(done[d]), 32'd0);
            chk($sformatf("dut%0d reset err", d), 32'(err[d]), 32'd0);
            chk($sformatf("dut%0d reset rdata", d), 32'(rdata[d]), 32'h0);
            chk($sformatf("dut%0d reset mem_rw_select", d), 32'(mrw[d]), 32'd0);
            chk($sformatf("dut%0d reset mem_address", d), 32'(maddr[d]), 32'd0);
            chk($sformatf("dut%0d reset mem_wdata", d), 32'(mwd[d]), 32'd0);
        end
        tb_init = 1'b0;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        checking = 1'b1;

        // Byte write to an LED byte: one write cycle, done in cycle 2.
        r0 = rw_cnt[0];
        run(0, 1'b1, 1'b0, 9'd508, 16'h0007, 2);
        chk("byte write cycles", 32'(rw_cnt[0] - r0), 32'd1);
        chk("byte write err", 32'(last_err[0]), 32'd0);

        // Halfword write to the LED pair, then read it back.
        r0 = rw_cnt[0];
        run(0, 1'b1, 1'b1, 9'd506, 16'hA55A, 3);
        chk("hw write cycles", 32'(rw_cnt[0] - r0), 32'd2);
        run(0, 1'b0, 1'b1, 9'd506, 16'h0000, 5);
        chk("hw readback rdata", 32'(rdata[0]), 32'hA55A);

        // Halfword read of the switch bytes.
        r0 = rw_cnt[0];
        run(0, 1'b0, 1'b1, 9'd504, 16'h0000, 5);
        chk("hw read rdata", 32'(rdata[0]), 32'h1234);
        chk("hw read write cycles", 32'(rw_cnt[0] - r0), 32'd0);

        // Halfword write straddling the read-only range.
        r0 = rw_cnt[0];
        run(0, 1'b1, 1'b1, 9'd502, 16'hBEEF, 3);
        chk("ro straddle cycles", 32'(rw_cnt[0] - r0), 32'd1);
        chk("ro straddle err", 32'(last_err[0]), 32'd1);

        // Byte write fully inside the read-only range.
        r0 = rw_cnt[0];
        run(0, 1'b1, 1'b0, 9'd504, 16'h0099, 2);
        chk("ro byte cycles", 32'(rw_cnt[0] - r0), 32'd0);
        chk("ro byte err", 32'(last_err[0]), 32'd1);

        // Byte read zero-extends.
        run(0, 1'b0, 1'b0, 9'd502, 16'h0000, 3);
        chk("byte read rdata", 32'(rdata[0]), 32'h00EF);

        // A request while busy is ignored.
        r0 = rw_cnt[0];
        dc = done_cnt[0];
        issue(0, 1'b0, 1'b1, 9'd506, 16'h0000, c0);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; size[0] = 1'b0; addr[0] = 9'd508; wdata[0] = 16'h00FF;
        @(negedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        wait_drain(0);
        chk("busy latency", 32'(done_cyc[0] - c0), 32'd5);
        chk("busy done count", 32'(done_cnt[0] - dc), 32'd1);
        chk("busy write cycles", 32'(rw_cnt[0] - r0), 32'd0);
        chk("busy rdata", 32'(rdata[0]), 32'hA55A);

        // Reset during the WAIT of a halfword read.
        dc = done_cnt[0];
        issue(0, 1'b0, 1'b1, 9'd504, 16'h0000, c0);
        @(posedge clk);
        #1;
        reset[0] = 1'b1;
        while (q0.size() > 1) void'(q0.pop_back());
        q0.push_back('{rw: 1'b0, addr: 9'd0, wd: 8'h00, chk_wd: 1'b1, done: 1'b0,
                       err: 1'b0, rd: 16'h0000, ready: 1'b1});
        last_rd[0] = 16'h0000;
        @(posedge clk);
        #1;
        reset[0] = 1'b0;
        wait_drain(0);
        repeat (6) @(posedge clk);
        #1;
        chk("reset abandon done count", 32'(done_cnt[0] - dc), 32'd0);
        run(0, 1'b0, 1'b0, 9'd506, 16'h0000, 3);
        chk("post-reset rdata", 32'(rdata[0]), 32'h005A);

        // Latency-3 instance: wrap-around halfword read.
        run(1, 1'b0, 1'b1, 9'd511, 16'h0000, 9);
        chk("wrap rdata", 32'(rdata[1]), 32'hABCD);

        // Halfword write starting in the read-only range, then read back.
        r0 = rw_cnt[1];
        run(1, 1'b1, 1'b1, 9'd505, 16'h7788, 3);
        chk("ro low byte cycles", 32'(rw_cnt[1] - r0), 32'd1);
        chk("ro low byte err", 32'(last_err[1]), 32'd1);
        run(1, 1'b0, 1'b1, 9'd505, 16'h0000, 9);
        chk("ro low byte rdata", 32'(rdata[1]), 32'h7712);
        run(1, 1'b0, 1'b0, 9'd0, 16'h0000, 5);
        chk("lat3 byte read rdata", 32'(rdata[1]), 32'h00AB);

        repeat (3) @(posedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the 512-byte memory-mapped GPIO/RAM bus.
- Accepts byte or halfword (16-bit) read/write requests from the CPU core.
- Sequences them into single-byte bus cycles on the 9-bit-address, 8-bit-data bus.
- Waits out the responder's registered read latency, assembles little-endian halfwords, and blocks writes to the read-only input bytes (buttons, switches).

Parameters:
- READ_LATENCY, 1: cycles from the address being driven until mem_rdata is valid; legal range 1..3.
- RO_LO, 503: lowest read-only byte address.
- RO_HI, 505: highest read-only byte address.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  CPU request strobe; sampled only while ready=1.
- we  input  1  1 = write, 0 = read; sampled with req.
- size  input  1  0 = byte, 1 = halfword; sampled with req.
- addr  input  9  byte address of the request; sampled with req.
- wdata  input  16  write data; [7:0] goes to addr, [15:8] goes to addr+1.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  16  read result, valid while done=1 and held until the next read completes.
- err  output  1  valid with done; set if any write byte was suppressed.
- mem_rw_select  output  1  to responder rw_select; 1 = write this cycle.
- mem_address  output  9  to responder address.
- mem_wdata  output  8  to responder data_in.
- mem_rdata  input  8  from responder data_out.

Behaviour:
- Reset values:
  - State is IDLE and ready=1.
  - done=0, err=0, rdata=16'h0000.
  - mem_rw_select=0, mem_address=0, mem_wdata=0.
- Reset mid-transaction: takes effect on the next edge. The transaction is abandoned, no done pulse is issued, and mem_rw_select=0 from that edge on.
- States: IDLE, ADDR, WAIT, DONE.
- IDLE:
  - If req=1, latch we, size, addr and wdata.
  - Set byte index k=0 and clear the err accumulator.
  - Go to ADDR.
  - req while not in IDLE is ignored; there is no queuing.
- ADDR:
  - Drive mem_address = addr + k, modulo 512 (511+1 wraps to 0).
  - Write: mem_wdata = wdata byte k. mem_rw_select=1 unless the byte address lies in RO_LO..RO_HI; in that case mem_rw_select=0 and err accumulates 1.
    - If more bytes remain: k increments, stay in ADDR.
    - Otherwise go to DONE.
  - Read: mem_rw_select=0, go to WAIT.
- WAIT:
  - Hold mem_address; mem_rw_select=0.
  - Stay for exactly READ_LATENCY cycles.
  - On the last WAIT cycle, capture mem_rdata into rdata byte k.
  - If more bytes remain: k increments and go to ADDR. Otherwise go to DONE.
- DONE:
  - done=1 for one cycle; err carries the accumulated value.
  - Byte read: rdata[15:8]=0.
  - Go to IDLE. ready returns the cycle after DONE, so back-to-back requests have a one-cycle IDLE gap.
- Latency, with request accepted in cycle 0:
  - Byte write: done in cycle 2.
  - Halfword write: done in cycle 3.
  - Byte read: done in cycle 2+READ_LATENCY.
  - Halfword read: done in cycle 3+2*READ_LATENCY.
- Outside ADDR write cycles, mem_rw_select is always 0.
- mem_address and mem_wdata hold their last values when idle.
- Byte order is little-endian (low byte at addr), matching the LED pair 506/507.
- A halfword that straddles the RO range (e.g. addr 502, or 505 to 506) writes only the legal byte and sets err.

Test Plan:
- Byte write: req, we=1, size=0, addr=508, wdata=16'h0007 -> exactly one cycle with mem_rw_select=1, mem_address=508, mem_wdata=8'h07; done in cycle 2 with err=0.
- Halfword write: addr=506, wdata=16'hA55A -> cycle 1 writes 506/5A, cycle 2 writes 507/A5; done in cycle 3. A follow-up halfword read returns rdata=16'hA55A.
- Halfword read, READ_LATENCY=1, responder model preloaded 504=8'h34, 505=8'h12 -> rdata=16'h1234 with done in cycle 5; mem_rw_select=0 throughout.
- Read-only protection: halfword write addr=502, wdata=16'hBEEF -> byte 502 written with EF, 503 not written (mem_rw_select=0), done with err=1. Also a byte write to 504 -> no write cycle, err=1.
- Wrap and latency: halfword read addr=511 with READ_LATENCY=3 -> mem_address sequence 511 then 0; done in cycle 9.
- Reset mid-operation: assert reset during the WAIT of a halfword read -> next edge gives ready=1, mem_rw_select=0, no done. A req asserted while busy is ignored (exactly one done seen per accepted req).
